// File: rtl/prbs_burst_ctrl.sv
// -----------------------------------------------------------------------------
// prbs_burst_ctrl
//
// Sequencing controller for a 4-bit parallel PRBS generator. On an accepted
// start it loads a seed into the generator, then advances the generator one
// word per accepted output transfer until the programmed number of words has
// been delivered on a valid/ready port. An all-zero LFSR state (lock-up) is
// detected while running and recovered from by reseeding with the latched seed.
//
// Ports
//   clk        single clock, rising-edge
//   rst        synchronous active-high reset
//   cfg_seed   seed, sampled on accepted start (zero -> DEFAULT_SEED)
//   cfg_len    burst length in 4-bit words, sampled on accepted start
//   start      begin burst (honoured only when idle)
//   abort      terminate burst (effective when not idle)
//   gen_load   generator load pulse (high for the single LOAD cycle)
//   gen_seed   seed presented to the generator
//   gen_en     generator advances one word at the next edge (combinational)
//   gen_word   current generator output word
//   gen_state  current generator LFSR state, for lock-up detection
//   out_word   registered PRBS word
//   out_valid  out_word valid
//   out_ready  downstream accepts
//   busy       burst in progress (LOAD, RUN, DRAIN)
//   done       one-cycle pulse, burst completed normally
//   aborted    one-cycle pulse, burst terminated by abort
//   lock_err   sticky lock-up flag, cleared by rst or accepted start
//   word_cnt   handshakes completed in current/last burst (saturating)
// -----------------------------------------------------------------------------
module prbs_burst_ctrl #(
  parameter int          LEN_W        = 16,
  parameter logic [7:0]  DEFAULT_SEED = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cfg_seed,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             start,
  input  logic             abort,
  output logic             gen_load,
  output logic [7:0]       gen_seed,
  output logic             gen_en,
  input  logic [3:0]       gen_word,
  input  logic [7:0]       gen_state,
  output logic [3:0]       out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             lock_err,
  output logic [LEN_W-1:0] word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             hs;
  logic             capture;
  logic             lockup;
  logic             abort_hit;

  assign hs        = out_valid && out_ready;
  assign abort_hit = abort && (state != IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and capture decision.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    lockup    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && (cfg_len != '0)) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = RUN;
      end
      RUN: begin
        // Lock-up takes priority over capture: the stuck word is never taken,
        // the generator is reseeded on the way back through LOAD.
        if (gen_state == 8'h00) begin
          lockup    = 1'b1;
          state_nxt = LOAD;
        end else if ((remaining != '0) && (!out_valid || out_ready)) begin
          capture = 1'b1;
          if (remaining == LEN_W'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides everything, including a final handshake or a lock-up.
    if (abort_hit) begin
      state_nxt = IDLE;
      capture   = 1'b0;
      lockup    = 1'b0;
    end
  end

  assign gen_en   = capture;
  assign gen_load = (state == LOAD);
  assign busy     = (state != IDLE);

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge regardless of order.
  // NOTE: reset covers every register here; there is no storage array that
  // would need to be left out of reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      gen_seed  <= DEFAULT_SEED;
      out_word  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      lock_err  <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      done    <= 1'b0;
      aborted <= 1'b0;

      if (hs && (word_cnt != '1)) word_cnt <= word_cnt + LEN_W'(1);

      // A capture refills the output register; a handshake without a
      // capture empties it.
      if (capture) begin
        out_word  <= gen_word;
        out_valid <= 1'b1;
        remaining <= remaining - LEN_W'(1);
      end else if (hs) begin
        out_valid <= 1'b0;
      end

      if (lockup) lock_err <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start) begin
            word_cnt <= '0;
            lock_err <= 1'b0;
            if (cfg_len == '0) begin
              done <= 1'b1;
            end else begin
              remaining <= cfg_len;
              gen_seed  <= (cfg_seed == 8'h00) ? DEFAULT_SEED : cfg_seed;
            end
          end
        end
        DRAIN: begin
          if (hs && !abort) done <= 1'b1;
        end
        default: ;
      endcase

      if (abort_hit) begin
        out_valid <= 1'b0;
        aborted   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prbs_burst_ctrl
//
// Bench for prbs_burst_ctrl. A small 8-bit LFSR generator model (x^8+x^6+x^5+
// x^4+1, four shifts per word) sits on the generator side; expected words are
// the k-th word after seeding, computed directly from the seed.
// -----------------------------------------------------------------------------
module tb_prbs_burst_ctrl;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       cfg_seed;
  logic [LEN_W-1:0] cfg_len;
  logic             start;
  logic             abort;
  logic             gen_load;
  logic [7:0]       gen_seed;
  logic             gen_en;
  logic [3:0]       gen_word;
  logic [7:0]       gen_state;
  logic [3:0]       out_word;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             lock_err;
  logic [LEN_W-1:0] word_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] lfsr = 8'h01;
  logic       force_zero = 1'b0;

  prbs_burst_ctrl #(.LEN_W(LEN_W), .DEFAULT_SEED(8'hFF)) dut (
    .clk(clk), .rst(rst), .cfg_seed(cfg_seed), .cfg_len(cfg_len),
    .start(start), .abort(abort), .gen_load(gen_load), .gen_seed(gen_seed),
    .gen_en(gen_en), .gen_word(gen_word), .gen_state(gen_state),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .aborted(aborted), .lock_err(lock_err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] adv4(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    for (int i = 0; i < 4; i++) r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    return r;
  endfunction

  // k-th word after seeding: seed state advanced k words, low nibble.
  function automatic logic [3:0] ref_word(input logic [7:0] seed, input int k);
    logic [7:0] r;
    r = seed;
    for (int i = 0; i < k; i++) r = adv4(r);
    return r[3:0];
  endfunction

  // Generator model driven by the controller's load/advance controls.
  assign gen_word  = lfsr[3:0];
  assign gen_state = force_zero ? 8'h00 : lfsr;
  always @(posedge clk) begin
    if (gen_load)    lfsr <= gen_seed;
    else if (gen_en) lfsr <= adv4(lfsr);
  end

  // Advance to 1 time unit after the next rising edge (input-drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    #1;
    n_cmp++;
    if ({out_valid, busy, done, aborted, lock_err, gen_load, gen_en} !== 7'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000000",
                        {out_valid, busy, done, aborted, lock_err, gen_load, gen_en});
    end
    n_cmp++;
    if ({word_cnt, out_word, gen_seed} !== {16'h0000, 4'h0, 8'hFF}) begin
      n_bad++; $display("FAIL reset_values: got cnt=%h word=%h seed=%h want 0/0/ff",
                        word_cnt, out_word, gen_seed);
    end
    cyc(); rst = 1'b0;
  endtask

  task automatic test_basic();
    cyc(); cfg_seed = 8'hA5; cfg_len = 16'd5; start = 1'b1; out_ready = 1'b1; #1;
    cyc(); start = 1'b0; #1;                                   // t+1: LOAD
    n_cmp++;
    if ({gen_load, busy, out_valid, gen_seed} !== {3'b110, 8'hA5}) begin
      n_bad++; $display("FAIL basic_load: got load=%b busy=%b ov=%b seed=%h want 1/1/0/a5",
                        gen_load, busy, out_valid, gen_seed);
    end
    cyc(); #1;                                                 // t+2: first capture
    n_cmp++;
    if ({gen_load, gen_en, out_valid} !== 3'b010) begin
      n_bad++; $display("FAIL basic_first_run: got load=%b en=%b ov=%b want 0/1/0",
                        gen_load, gen_en, out_valid);
    end
    for (int k = 0; k < 5; k++) begin                          // t+3 .. t+7
      cyc(); #1;
      n_cmp++;
      if ({out_valid, busy, done, out_word, gen_en} !==
          {3'b110, ref_word(8'hA5, k), (k < 4) ? 1'b1 : 1'b0}) begin
        n_bad++; $display("FAIL basic_word%0d: got ov=%b busy=%b done=%b w=%h en=%b want 1/1/0/%h/%b",
                          k, out_valid, busy, done, out_word, gen_en, ref_word(8'hA5, k), k < 4);
      end
    end
    cyc(); #1;                                                 // t+8: done
    n_cmp++;
    if ({done, busy, out_valid, lock_err, word_cnt} !== {4'b1000, 16'd5}) begin
      n_bad++; $display("FAIL basic_done: got done=%b busy=%b ov=%b lerr=%b cnt=%0d want 1/0/0/0/5",
                        done, busy, out_valid, lock_err, word_cnt);
    end
  endtask

  // Generic burst with scoreboard. mode 0: ready held 1; 1: ready 1,0,0,1
  // pattern; 2: random ready. mid_start pulses a second start while busy.
  task automatic run_burst(input logic [7:0] seed, input int len, input int mode,
                           input bit mid_start, input bit abort_on_start, input string tag);
    logic [7:0] eff;
    logic [3:0] got[$];
    logic [3:0] held;
    bit         held_v;
    bit         fin;
    int         en_cnt;
    logic [31:0] len_v;
    eff = (seed == 8'h00) ? 8'hFF : seed;
    held = 4'h0; held_v = 1'b0; fin = 1'b0; en_cnt = 0;
    len_v = len;
    cyc(); cfg_seed = seed; cfg_len = len_v[LEN_W-1:0]; start = 1'b1;
    abort = abort_on_start; out_ready = 1'b0; #1;
    cyc(); start = 1'b0; abort = 1'b0; #1;
    if (len == 0) begin
      n_cmp++;
      if ({done, busy, gen_load, word_cnt} !== {3'b100, 16'd0}) begin
        n_bad++; $display("FAIL %s_zero_len: got done=%b busy=%b load=%b cnt=%0d want 1/0/0/0",
                          tag, done, busy, gen_load, word_cnt);
      end
      cyc(); #1;
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
        n_bad++; $display("FAIL %s_zero_len_after: got done=%b busy=%b want 0/0", tag, done, busy);
      end
      return;
    end
    n_cmp++;
    if ({gen_load, busy, lock_err, word_cnt, gen_seed} !== {3'b110, 16'd0, eff}) begin
      n_bad++; $display("FAIL %s_load: got load=%b busy=%b lerr=%b cnt=%0d seed=%h want 1/1/0/0/%h",
                        tag, gen_load, busy, lock_err, word_cnt, gen_seed, eff);
    end
    for (int i = 0; i < 40 * len + 40 && !fin; i++) begin
      cyc();
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((i % 4) == 0) || ((i % 4) == 3);
        default: out_ready = ($urandom_range(99) < 60);
      endcase
      if (mid_start && i == 2) begin
        start = 1'b1; cfg_seed = ~eff; cfg_len = len_v[LEN_W-1:0] + 16'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      if (done) begin
        fin = 1'b1;
      end else begin
        if (held_v) begin
          n_cmp++;
          if ({out_valid, out_word} !== {1'b1, held}) begin
            n_bad++; $display("FAIL %s_hold: got ov=%b w=%h want 1/%h", tag, out_valid, out_word, held);
          end
        end
        if (out_valid && !out_ready) begin
          n_cmp++;
          if (gen_en !== 1'b0) begin
            n_bad++; $display("FAIL %s_stall_en: got gen_en=%b want 0", tag, gen_en);
          end
        end
        if (gen_en) en_cnt++;
        if (out_valid && out_ready) begin
          got.push_back(out_word);
          held_v = 1'b0;
        end else begin
          held_v = out_valid;
          held   = out_word;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (!fin) begin
      n_bad++; $display("FAIL %s_timeout: got no done want done", tag);
    end
    n_cmp++;
    if (got.size() != len || en_cnt != len) begin
      n_bad++; $display("FAIL %s_count: got words=%0d advances=%0d want %0d", tag, got.size(), en_cnt, len);
    end
    for (int i = 0; i < got.size() && i < len; i++) begin
      n_cmp++;
      if (got[i] !== ref_word(eff, i)) begin
        n_bad++; $display("FAIL %s_word%0d: got %h want %h", tag, i, got[i], ref_word(eff, i));
      end
    end
    n_cmp++;
    if ({busy, word_cnt} !== {1'b0, len_v[LEN_W-1:0]}) begin
      n_bad++; $display("FAIL %s_final: got busy=%b cnt=%0d want 0/%0d", tag, busy, word_cnt, len);
    end
  endtask

  task automatic test_backpressure();
    run_burst(8'($urandom_range(254, 1)), 4, 1, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_zero_seed_len();
    run_burst(8'h00, 3, 2, 1'b0, 1'b0, "zero_seed");
    run_burst(8'h3C, 0, 0, 1'b0, 1'b0, "zero_len");
  endtask

  task automatic test_lockup();
    logic [7:0] seed;
    logic [3:0] got[$];
    logic [3:0] exp[$];
    bit         forced;
    bit         fin;
    int         hs_n;
    int         fz_cyc;
    seed = 8'($urandom_range(254, 1));
    forced = 1'b0; fin = 1'b0; hs_n = 0; fz_cyc = -10;
    // Three words are out before the lock (two taken, one pending), then the
    // reseed restarts the sequence for the remaining three.
    for (int i = 0; i < 3; i++) exp.push_back(ref_word(seed, i));
    for (int i = 0; i < 3; i++) exp.push_back(ref_word(seed, i));
    cyc(); cfg_seed = seed; cfg_len = 16'd6; start = 1'b1; out_ready = 1'b1; #1;
    cyc(); start = 1'b0; #1;
    for (int i = 0; i < 80 && !fin; i++) begin
      cyc();
      out_ready  = 1'b1;
      force_zero = 1'b0;
      if (!forced && hs_n == 2 && out_valid) begin
        force_zero = 1'b1; forced = 1'b1; fz_cyc = i;
      end
      #1;
      if (force_zero) begin
        n_cmp++;
        if (gen_en !== 1'b0) begin
          n_bad++; $display("FAIL lockup_no_capture: got gen_en=%b want 0", gen_en);
        end
      end
      if (i == fz_cyc + 1) begin
        n_cmp++;
        if ({gen_load, lock_err, gen_seed} !== {2'b11, seed}) begin
          n_bad++; $display("FAIL lockup_reload: got load=%b lerr=%b seed=%h want 1/1/%h",
                            gen_load, lock_err, gen_seed, seed);
        end
      end
      if (done) begin
        fin = 1'b1;
      end else if (out_valid && out_ready) begin
        got.push_back(out_word);
        hs_n++;
      end
    end
    force_zero = 1'b0;
    n_cmp++;
    if (!fin || !forced) begin
      n_bad++; $display("FAIL lockup_timeout: got done=%b forced=%b want 1/1", fin, forced);
    end
    n_cmp++;
    if (got.size() != 6) begin
      n_bad++; $display("FAIL lockup_count: got %0d want 6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL lockup_word%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
    cyc(); #1;
    n_cmp++;
    if ({lock_err, word_cnt} !== {1'b1, 16'd6}) begin
      n_bad++; $display("FAIL lockup_sticky: got lerr=%b cnt=%0d want 1/6", lock_err, word_cnt);
    end
  endtask

  // Start+abort together in IDLE, and a second start mid-burst; the following
  // burst also shows lock_err cleared by an accepted start.
  task automatic test_start_busy();
    run_burst(8'($urandom_range(254, 1)), 6, 0, 1'b1, 1'b1, "start_busy");
  endtask

  task automatic test_abort();
    bit stop;
    int hs_n;
    stop = 1'b0; hs_n = 0;
    cyc(); cfg_seed = 8'h5A; cfg_len = 16'd10; start = 1'b1; out_ready = 1'b1; #1;
    cyc(); start = 1'b0; #1;
    for (int i = 0; i < 60 && !stop; i++) begin
      cyc();
      if (hs_n == 3 && out_valid) begin
        out_ready = 1'b0; abort = 1'b1; stop = 1'b1; #1;
      end else begin
        out_ready = 1'b1; #1;
        if (out_valid && out_ready) hs_n++;
      end
    end
    cyc(); abort = 1'b0; #1;
    n_cmp++;
    if (!stop || {out_valid, aborted, busy, done, word_cnt} !== {4'b0100, 16'd3}) begin
      n_bad++; $display("FAIL abort_mid: got ov=%b ab=%b busy=%b done=%b cnt=%0d want 0/1/0/0/3",
                        out_valid, aborted, busy, done, word_cnt);
    end
    cyc(); #1;
    n_cmp++;
    if ({done, aborted} !== 2'b00) begin
      n_bad++; $display("FAIL abort_mid_after: got done=%b ab=%b want 0/0", done, aborted);
    end

    // Abort coincident with the final handshake.
    stop = 1'b0; hs_n = 0;
    cyc(); cfg_seed = 8'h11; cfg_len = 16'd2; start = 1'b1; out_ready = 1'b1; #1;
    cyc(); start = 1'b0; #1;
    for (int i = 0; i < 40 && !stop; i++) begin
      cyc(); out_ready = 1'b1;
      if (hs_n == 1 && out_valid) begin
        abort = 1'b1; stop = 1'b1;
      end
      #1;
      if (!stop && out_valid) hs_n++;
    end
    cyc(); abort = 1'b0; #1;
    n_cmp++;
    if (!stop || {aborted, done, busy, out_valid} !== 4'b1000) begin
      n_bad++; $display("FAIL abort_final: got ab=%b done=%b busy=%b ov=%b want 1/0/0/0",
                        aborted, done, busy, out_valid);
    end
    cyc(); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL abort_final_after: got done=%b want 0", done);
    end
  endtask

  task automatic test_reset_mid();
    bit stop;
    int hs_n;
    stop = 1'b0; hs_n = 0;
    cyc(); cfg_seed = 8'($urandom_range(254, 1)); cfg_len = 16'd8; start = 1'b1; out_ready = 1'b1; #1;
    cyc(); start = 1'b0; #1;
    for (int i = 0; i < 40 && !stop; i++) begin
      cyc();
      if (hs_n == 2 && out_valid) begin
        rst = 1'b1; out_ready = 1'b0; stop = 1'b1; #1;
      end else begin
        out_ready = 1'b1; #1;
        if (out_valid) hs_n++;
      end
    end
    cyc(); rst = 1'b0; #1;
    n_cmp++;
    if (!stop || {out_valid, busy, done, aborted, lock_err, gen_load, gen_en} !== 7'b0) begin
      n_bad++; $display("FAIL reset_mid_flags: got %b want 0000000",
                        {out_valid, busy, done, aborted, lock_err, gen_load, gen_en});
    end
    n_cmp++;
    if ({word_cnt, out_word, gen_seed} !== {16'h0000, 4'h0, 8'hFF}) begin
      n_bad++; $display("FAIL reset_mid_values: got cnt=%0d w=%h seed=%h want 0/0/ff",
                        word_cnt, out_word, gen_seed);
    end
    cyc(); #1;
    n_cmp++;
    if ({busy, done, aborted} !== 3'b000) begin
      n_bad++; $display("FAIL reset_mid_after: got busy=%b done=%b ab=%b want 0/0/0", busy, done, aborted);
    end
  endtask

  task automatic test_random();
    logic [7:0] seed;
    for (int n = 0; n < 6; n++) begin
      seed = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
      run_burst(seed, $urandom_range(12, 1), 2, 1'b0, 1'b0, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_seed = 8'h00; cfg_len = '0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_seed_len();
    test_lockup();
    test_start_busy();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
